uart_sched: RTL and testbench

UART_SCHED -- requirements
Module: uart_sched

---
 rtl/uart_sched.sv | 184 ++++++++++++++++++
 tb/tb_uart_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sched.sv
// rtl/uart_sched.sv - two-requester round-robin scheduler driving a 32-bit UART controller
module uart_sched #(
    parameter int LOAD_CYC  = 16,
    parameter int CLOSE_CYC = 4,
    parameter int TO_W      = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_wr,
    input  logic [63:0] rq_wdata,
    output logic [1:0]  rq_ack,
    output logic [1:0]  rq_done,
    output logic        rq_err,
    output logic [31:0] rq_rdata,
    output logic [2:0]  UnUc_wr_sel,
    output logic [31:0] UbUc_data_in,
    output logic        UbUc_data_in_en,
    input  logic        UcUn_txd_valid,
    input  logic        UcUn_rxd_ready,
    input  logic [31:0] UcUb_data_out
);

    localparam int CNT_MAX = (LOAD_CYC > CLOSE_CYC) ? LOAD_CYC : CLOSE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   LOAD_LAST  = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0]   CLOSE_LAST = CW'(CLOSE_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST    = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_CLOSE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      tx_sync_q, tx_sync_d;
    logic [2:0]      rx_sync_q, rx_sync_d;
    logic            ptr_q, ptr_d;
    logic            sel_q, sel_d;
    logic            wr_q, wr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      ack_q, ack_d;

    logic any_req, grant_idx, tx_rise, rx_rise, edge_hit, timeout;
    logic load_last, close_last;

    // [0]/[1] are the synchronizer pair, [2] holds the previous synchronized level
    assign tx_rise    = tx_sync_q[1] & ~tx_sync_q[2];
    assign rx_rise    = rx_sync_q[1] & ~rx_sync_q[2];
    assign any_req    = |rq_valid;
    assign grant_idx  = (&rq_valid) ? ~ptr_q : rq_valid[1];
    assign edge_hit   = wr_q ? tx_rise : rx_rise;
    assign timeout    = (to_q == TO_LAST);
    assign load_last  = (cnt_q == LOAD_LAST);
    assign close_last = (cnt_q == CLOSE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_OPEN;
            S_OPEN:  state_d = wr_q ? S_LOAD : S_WAIT;
            S_LOAD:  if (load_last) state_d = S_WAIT;
            S_WAIT:  if (edge_hit || timeout) state_d = S_CLOSE;
            S_CLOSE: if (close_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_sync_d = {tx_sync_q[1:0], UcUn_txd_valid};
        rx_sync_d = {rx_sync_q[1:0], UcUn_rxd_ready};
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        ack_d     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    ack_d     = grant_idx ? 2'b10 : 2'b01;
                    ptr_d     = grant_idx;
                    sel_d     = grant_idx;
                    wr_d      = rq_wr[grant_idx];
                    wdata_d   = grant_idx ? rq_wdata[63:32] : rq_wdata[31:0];
                    cnt_d     = '0;
                    to_d      = '0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                end
            end
            S_OPEN:  cnt_d = '0;
            S_LOAD:  cnt_d = load_last ? '0 : cnt_q + CW'(1);
            S_WAIT: begin
                to_d  = to_q + TO_W'(1);
                cnt_d = '0;
                // an edge in the timeout cycle still counts as success
                if (edge_hit) begin
                    err_d = 1'b0;
                    if (!wr_q) rdata_d = UcUb_data_out;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_CLOSE: cnt_d = cnt_q + CW'(1);
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sync_q <= '0;
            rx_sync_q <= '0;
            ptr_q     <= 1'b1;
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 2'b00;
        end else begin
            tx_sync_q <= tx_sync_d;
            rx_sync_q <= rx_sync_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
        end
    end

    // ack is registered so it is clean during reset; it coincides with the OPEN cycle
    always_comb begin
        rq_ack          = ack_q;
        rq_done         = 2'b00;
        rq_err          = 1'b0;
        rq_rdata        = '0;
        UnUc_wr_sel     = 3'b000;
        UbUc_data_in    = '0;
        UbUc_data_in_en = 1'b0;
        case (state_q)
            S_OPEN: UnUc_wr_sel = wr_q ? 3'b100 : 3'b010;
            S_LOAD: begin
                UbUc_data_in_en = 1'b1;
                UbUc_data_in    = wdata_q;
            end
            S_CLOSE: begin
                UnUc_wr_sel = 3'b001;
                if (close_last) begin
                    rq_done  = sel_q ? 2'b10 : 2'b01;
                    rq_err   = err_q;
                    rq_rdata = rdata_q;
                end
            end
            default: UnUc_wr_sel = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_uart_sched.sv
// tb/tb_uart_sched.sv - randomized scoreboard bench for uart_sched against a timing-level reference model
module tb_uart_sched;

    localparam int LOAD_CYC  = 16;
    localparam int CLOSE_CYC = 4;
    localparam int TO_W      = 4;
    localparam int MAXW      = (1 << TO_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rq_valid, rq_wr, rq_ack, rq_done;
    logic [63:0] rq_wdata;
    logic        rq_err;
    logic [31:0] rq_rdata, UbUc_data_in, UcUb_data_out;
    logic [2:0]  UnUc_wr_sel;
    logic        UbUc_data_in_en, UcUn_txd_valid, UcUn_rxd_ready;

    logic        vld [2];
    logic        wrb [2];
    logic [31:0] wd  [2];

    logic        req_wr   [2];
    logic [31:0] req_data [2];
    logic [31:0] rx_word  [2];
    int          req_d    [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_until = 0;

    typedef struct {
        int          idx;
        bit          wr;
        bit          err;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;
    exp_t sb[$];

    bit pend = 0, pend_idx = 0, active = 0, ptr = 1, act_wr = 0;
    int act_cyc = 0, act_done = 0, free_cyc = 0;
    logic [31:0] act_data = '0;

    bit armed = 0, cur_wr = 0;
    int ctr = 0, dly = 0;

    assign rq_valid = {vld[1], vld[0]};
    assign rq_wr    = {wrb[1], wrb[0]};
    assign rq_wdata = {wd[1], wd[0]};

    uart_sched #(.LOAD_CYC(LOAD_CYC), .CLOSE_CYC(CLOSE_CYC), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(rq_valid), .rq_wr(rq_wr), .rq_wdata(rq_wdata),
        .rq_ack(rq_ack), .rq_done(rq_done), .rq_err(rq_err), .rq_rdata(rq_rdata),
        .UnUc_wr_sel(UnUc_wr_sel), .UbUc_data_in(UbUc_data_in), .UbUc_data_in_en(UbUc_data_in_en),
        .UcUn_txd_valid(UcUn_txd_valid), .UcUn_rxd_ready(UcUn_rxd_ready), .UcUb_data_out(UcUb_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART controller stand-in: raises the done level dly cycles after the mode command
    always @(negedge clk) begin
        if (!rst_n) begin
            armed = 0;
            UcUn_txd_valid = 1'b0;
            UcUn_rxd_ready = 1'b0;
        end else begin
            if (UnUc_wr_sel == 3'b100 || UnUc_wr_sel == 3'b010) begin
                armed = 1;
                ctr = 0;
                cur_wr = (UnUc_wr_sel == 3'b100);
                dly = req_d[rq_ack[1]];
                UcUb_data_out = rx_word[rq_ack[1]];
            end else if (armed) begin
                ctr++;
            end
            if (|rq_done) armed = 0;
            UcUn_txd_valid = (armed && cur_wr && ctr >= dly) || (cyc < pulse_until);
            UcUn_rxd_ready = armed && !cur_wr && ctr >= dly;
        end
    end

    // Reference model and scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        int rise, ws, w, k;
        bit hit;
        logic [2:0] exp_sel;
        logic exp_en;
        logic [31:0] exp_din;
        if (!rst_n) begin
            check("rst_ack", 32'(rq_ack), 0);
            check("rst_done", 32'(rq_done), 0);
            check("rst_sel", 32'(UnUc_wr_sel), 0);
            check("rst_en", 32'(UbUc_data_in_en), 0);
            check("rst_din", UbUc_data_in, 0);
            check("rst_err", 32'(rq_err), 0);
            check("rst_rdata", rq_rdata, 0);
            sb.delete();
            pend = 0; active = 0; ptr = 1; free_cyc = 0;
        end else begin
            check("ack", 32'(rq_ack), pend ? (pend_idx ? 32'd2 : 32'd1) : 32'd0);
            if (pend) begin
                rise = req_d[pend_idx] + 2;
                ws = req_wr[pend_idx] ? 1 + LOAD_CYC : 1;
                hit = (rise >= ws) && (rise - ws + 1 <= MAXW);
                w = hit ? rise - ws + 1 : MAXW;
                e.idx = int'(pend_idx);
                e.wr = req_wr[pend_idx];
                e.err = !hit;
                e.rdata = hit ? rx_word[pend_idx] : 32'd0;
                e.done_cyc = cyc + (e.wr ? LOAD_CYC : 0) + w + CLOSE_CYC;
                sb.push_back(e);
                act_cyc = cyc; act_wr = e.wr; act_data = req_data[pend_idx];
                act_done = e.done_cyc; free_cyc = e.done_cyc + 1;
                active = 1; ptr = pend_idx; pend = 0;
            end
            exp_sel = 3'b000; exp_en = 1'b0; exp_din = '0;
            if (active) begin
                k = cyc - act_cyc;
                if (k == 0) exp_sel = act_wr ? 3'b100 : 3'b010;
                else if (act_wr && k <= LOAD_CYC) begin
                    exp_en = 1'b1;
                    exp_din = act_data;
                end
                if (cyc > act_done - CLOSE_CYC && cyc <= act_done) exp_sel = 3'b001;
            end
            check("wr_sel", 32'(UnUc_wr_sel), 32'(exp_sel));
            check("data_in_en", 32'(UbUc_data_in_en), 32'(exp_en));
            check("data_in", UbUc_data_in, exp_din);
            if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
                e = sb.pop_front();
                check("done", 32'(rq_done), e.idx ? 32'd2 : 32'd1);
                check("err", 32'(rq_err), 32'(e.err));
                if (!e.wr) check("rdata", rq_rdata, e.rdata);
                active = 0;
            end else begin
                check("done_idle", 32'(rq_done), 0);
            end
            if (!pend && !active && cyc >= free_cyc && rq_valid != 2'b00) begin
                pend = 1;
                pend_idx = (rq_valid == 2'b11) ? !ptr : rq_valid[1];
            end
        end
    end

    task automatic request(input int i, input bit wr, input logic [31:0] wdat,
                           input logic [31:0] rxw, input int d);
        int n;
        @(posedge clk); #1;
        req_wr[i] = wr; req_data[i] = wdat; rx_word[i] = rxw; req_d[i] = d;
        wrb[i] = wr; wd[i] = wdat; vld[i] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rq_ack[i] && n < 1000);
        check("ack_wait", 32'(rq_ack[i]), 1);
        vld[i] = 1'b0;
        wd[i] = $urandom;
        wrb[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || pend || active || vld[0] || vld[1]) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 2000), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        vld[0] = 0; vld[1] = 0; wrb[0] = 0; wrb[1] = 0; wd[0] = '0; wd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            req_wr[i] = 0; req_data[i] = '0; rx_word[i] = '0; req_d[i] = 0;
        end
        UcUb_data_out = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        request(0, 1, 32'hA5A5_1234, $urandom, 20);
        request(1, 0, $urandom, 32'hDEAD_BEEF, 5);
        wait_idle();

        for (int r = 0; r < 2; r++) begin
            fork
                request(0, 1, $urandom, $urandom, 20);
                request(1, 0, $urandom, $urandom, 4);
            join
        end
        wait_idle();

        request(0, 0, $urandom, $urandom, 40);
        request(1, 0, $urandom, 32'h0BAD_F00D, 13);
        request(0, 0, $urandom, $urandom, 14);
        request(1, 1, $urandom, $urandom, 29);
        request(0, 1, $urandom, $urandom, 30);
        request(1, 1, $urandom, $urandom, 10);
        request(0, 0, $urandom, 32'h1111_2222, 0);
        wait_idle();

        pulse_until = cyc + 3;
        repeat (8) @(posedge clk);
        request(0, 1, 32'hC0DE_0041, $urandom, 20);
        wait_idle();

        request(0, 1, 32'h1357_9BDF, $urandom, 20);
        repeat (4) @(posedge clk);
        #2;
        check("load_before_rst", 32'(UbUc_data_in_en), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(UbUc_data_in_en), 0);
        check("async_rst_din", UbUc_data_in, 0);
        check("async_rst_sel", 32'(UnUc_wr_sel), 0);
        check("async_rst_done", 32'(rq_done), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        request(1, 0, $urandom, 32'h5A5A_0F0F, 3);
        wait_idle();

        fork
            for (int j = 0; j < 14; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                request(0, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 32)));
            end
            for (int j = 0; j < 14; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                request(1, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 32)));
            end
        join
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
